// File: rtl/ascon_inv_diffusion_layer.sv
// Iterative inverse of the Ascon linear layer: six nilpotent-series steps, UNROLL per clock.
// Optional self-check (forward re-diffusion compare, err_o) under ASCON_INV_DIFF_SELFCHECK_EN.
package ascon_inv_diff_pkg;
    typedef logic [4:0][63:0] type_state;
endpackage

module ascon_inv_diffusion_layer
    import ascon_inv_diff_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic      clock_i,
    input  logic      reset_i,
    input  logic      valid_i,
    output logic      ready_o,
    input  type_state state_i,
    output logic      valid_o,
    input  logic      ready_i,
    output type_state state_o
`ifdef ASCON_INV_DIFF_SELFCHECK_EN
    ,
    output logic      err_o
`endif
);
    localparam logic [4:0][5:0] ROT_A     = {6'd7, 6'd10, 6'd1, 6'd61, 6'd19};
    localparam logic [4:0][5:0] ROT_B     = {6'd41, 6'd17, 6'd6, 6'd39, 6'd28};
    localparam logic [2:0]      STEP_INC  = 3'(UNROLL);
    localparam logic [2:0]      STEP_LAST = 3'd6;

    typedef enum logic [1:0] {IDLE, COMPUTE, HOLD} state_t;

    state_t    r_fsm, w_fsm_nxt;
    logic [2:0] r_cnt, w_cnt_nxt;
    type_state r_work, w_work_nxt;
    type_state w_stage [UNROLL+1];

    // Shifting by 64 yields zero, so s = 0 correctly returns w.
    function automatic logic [63:0] ror64(input logic [63:0] w, input logic [5:0] s);
        return (w >> s) | (w << (7'd64 - {1'b0, s}));
    endfunction

    // One factor (I + N^(2^m)); amounts wrap mod 64 through the 6-bit truncation.
    function automatic logic [63:0] inv_step(input logic [63:0] w, input logic [5:0] a,
                                             input logic [5:0] b, input logic [2:0] m);
        logic [5:0] sa, sb;
        sa = a << m;
        sb = b << m;
        return w ^ ror64(w, sa) ^ ror64(w, sb);
    endfunction

    assign w_stage[0] = r_work;

    for (genvar k = 0; k < UNROLL; k++) begin : g_step
        for (genvar i = 0; i < 5; i++) begin : g_word
            assign w_stage[k+1][i] = inv_step(w_stage[k][i], ROT_A[i], ROT_B[i], r_cnt + 3'(k));
        end
    end

    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_cnt_nxt  = r_cnt;
        w_work_nxt = r_work;
        ready_o    = 1'b0;
        valid_o    = 1'b0;
        unique case (r_fsm)
            IDLE: begin
                ready_o = 1'b1;
                if (valid_i) begin
                    w_work_nxt = state_i;
                    w_cnt_nxt  = 3'd0;
                    w_fsm_nxt  = COMPUTE;
                end
            end
            COMPUTE: begin
                w_work_nxt = w_stage[UNROLL];
                w_cnt_nxt  = r_cnt + STEP_INC;
                if (w_cnt_nxt >= STEP_LAST)
                    w_fsm_nxt = HOLD;
            end
            HOLD: begin
                valid_o = 1'b1;
                if (ready_i)
                    w_fsm_nxt = IDLE;
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_fsm  <= IDLE;
            r_cnt  <= 3'd0;
            r_work <= '0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_cnt  <= w_cnt_nxt;
            r_work <= w_work_nxt;
        end
    end

    assign state_o = r_work;

`ifdef ASCON_INV_DIFF_SELFCHECK_EN
    type_state r_copy;
    logic      r_err;

    function automatic type_state sigma_fwd(input type_state x);
        type_state y;
        for (int i = 0; i < 5; i++)
            y[i] = x[i] ^ ror64(x[i], ROT_A[i]) ^ ror64(x[i], ROT_B[i]);
        return y;
    endfunction

    // Compare on the edge entering HOLD so err_o is settled for the whole HOLD phase.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_copy <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_fsm == IDLE && valid_i)
                r_copy <= state_i;
            if (r_fsm == COMPUTE && w_fsm_nxt == HOLD)
                r_err <= (sigma_fwd(w_work_nxt) != r_copy);
            else if (r_fsm == HOLD && ready_i)
                r_err <= 1'b0;
        end
    end

    assign err_o = r_err;
`endif

endmodule
